// File: rtl/dmem_dma.sv
// Block copy / fill / checksum engine that masters the 8-bit data-memory port; build with DMA_SUM_EN for checksum mode.
// Latency: copy takes 2N+1 cycles, fill and sum take N+1 cycles, and len=0 or a reserved mode takes 1 cycle from the start edge.
// Backpressure: none; start is ignored unless idle, and memory accesses are single-cycle.
module dmem_dma #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_FILL, S_SUM, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] i, i_inc;
    logic [AW-1:0] src_q, dst_q, len_q;
    logic [DW-1:0] fill_q, hold;
    logic          last;

    assign i_inc = i + 1'b1;
    assign last  = (i_inc == len_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            i      <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
            hold   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q  <= src;
                        dst_q  <= dst;
                        len_q  <= len;
                        fill_q <= fill_val;
                        i      <= '0;
                    end
                end
                S_RD:   hold <= mem_rd;
                S_WR, S_FILL, S_SUM: i <= i_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        case (mode)
                            2'b00:   state_nx = S_RD;
                            2'b01:   state_nx = S_FILL;
`ifdef DMA_SUM_EN
                            2'b10:   state_nx = S_SUM;
`endif
                            default: state_nx = S_DONE;
                        endcase
                    end
                end
            end
            S_RD:   state_nx = S_WR;
            S_WR:   state_nx = last ? S_DONE : S_RD;
            S_FILL: state_nx = last ? S_DONE : S_FILL;
            S_SUM:  state_nx = last ? S_DONE : S_SUM;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Port outputs come only from registered state so the mux ahead of memory sees no start-to-address path.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        mem_a  = '0;
        mem_we = 1'b0;
        mem_wd = '0;
        case (state)
            S_RD: begin
                busy  = 1'b1;
                mem_a = src_q + i;
            end
            S_WR: begin
                busy   = 1'b1;
                mem_a  = dst_q + i;
                mem_we = 1'b1;
                mem_wd = hold;
            end
            S_FILL: begin
                busy   = 1'b1;
                mem_a  = dst_q + i;
                mem_we = 1'b1;
                mem_wd = fill_q;
            end
            S_SUM: begin
                busy  = 1'b1;
                mem_a = src_q + i;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef DMA_SUM_EN
    logic [DW-1:0] acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (state == S_IDLE && start) begin
            acc <= '0;
        end else if (state == S_SUM) begin
            acc <= acc + mem_rd;
        end
    end

    assign result = acc;
`else
    assign result = '0;
`endif

endmodule

// File: doc/dmem_dma.md
# dmem_dma

Block-transfer engine that acts as the initiator on the 8-bit data-memory port (A / WE / WD / RD). It drives a memory with combinational read and synchronous write. On a start pulse it performs a byte copy, a constant fill, or a byte checksum over a region of memory without CPU involvement, then reports completion. It sits beside the datapath on the data-memory port, ahead of the memory in the port mux.

## Interface
- AW, 8, address width; region addresses wrap modulo 2^AW
- DW, 8, data width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- mode  in  2  00 copy, 01 fill, 10 sum, 11 reserved
- src  in  AW  source base address (copy, sum)
- dst  in  AW  destination base address (copy, fill)
- len  in  AW  byte count, 0..255; 0 means no accesses
- fill_val  in  DW  fill byte
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- result  out  DW  sum of bytes mod 2^DW; valid from done until next start
- mem_a  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory read data, combinational from mem_a

## Operation
- States: IDLE, RD, WR, FILL, SUM, DONE.
- IDLE, start=1: latch mode, src, dst, len, fill_val; clear index i and result.
  - len=0 or mode=11: go to DONE.
  - Otherwise go to RD (copy), FILL, or SUM according to mode.
- RD: mem_a=src+i, mem_we=0; hold register <= mem_rd; next state WR.
- WR: mem_a=dst+i, mem_we=1, mem_wd=hold. Then i<=i+1; go to DONE if i+1==len, else go to RD.
- FILL: mem_a=dst+i, mem_we=1, mem_wd=fill_val. Then i++; go to DONE on last byte.
- SUM: mem_a=src+i, mem_we=0; result<=result+mem_rd, truncated to DW bits. Then i++; go to DONE on last byte.
- DONE: done=1, busy=0; next state IDLE.
- busy=1 exactly in RD, WR, FILL, SUM.
- In IDLE and DONE: mem_a=0, mem_we=0, mem_wd=0.
- Address arithmetic is AW bits and wraps; e.g. src=0xFE, len=4 touches 0xFE, 0xFF, 0x00, 0x01.
- Copy order is strictly ascending, one read then one write per byte.
  - Overlap with dst>src therefore propagates already-copied data.
  - This behaviour is defined and required.
- start is ignored while busy and in DONE. Input operands may change freely after acceptance.
- result holds its value after DONE until the next accepted start. Copy and fill leave it 0.

## Timing
- Reset (rst=0 at an edge) forces IDLE on that edge from any state, including mid-transfer. After the edge: busy=0, done=0, result=0, mem_a=0, mem_we=0, mem_wd=0, i=0, hold=0. No write occurs in the reset cycle.
- Let start be accepted at edge 0.
  - Copy of N>0 bytes: accesses in cycles 1..2N; done high in cycle 2N+1.
  - Fill or sum of N>0 bytes: accesses in cycles 1..N; done in cycle N+1.
  - len=0 or mode=11: done in cycle 1; no write ever asserted.
- A new start is accepted in the cycle after done, at the earliest.
- mem_a, mem_we and mem_wd are decoded from registered state only. They have no combinational path from start or other inputs.

## Configuration
- DMA_SUM_EN defined: SUM state, accumulator and result register are present; mode 10 behaves as specified.
- DMA_SUM_EN undefined: mode 10 is treated as reserved (done in cycle 1, no accesses), and result is tied to 0.

## Test plan
- Reset mid-copy: start copy src=0x10, dst=0x80, len=8, then assert rst=0 during cycle 5. Required: busy=0 and mem_we=0 next cycle; at most bytes 0x80..0x81 written; no done pulse.
- Copy: memory[0x10..0x13]={0xA1,0xB2,0xC3,0xD4}, copy to dst=0x40, len=4. Required: done in cycle 9; memory[0x40..0x43] equals source; source unchanged.
- Fill with wrap: dst=0xFD, len=5, fill_val=0x5A. Required: 0xFD, 0xFE, 0xFF, 0x00, 0x01 equal 0x5A; 0x02 untouched; done in cycle 6.
- Sum: memory[0x20..0x22]={0xF0,0x20,0x05}, mode=10, len=3. Required: result=0x15 in the done cycle; result held afterwards (with DMA_SUM_EN). Without DMA_SUM_EN: done in cycle 1, result=0.
- len=0 and mode=11: done in cycle 1; mem_we never high; busy never high.
- start held high during an active fill: no restart, and exactly one done pulse. start high in the cycle after done begins a new transfer.
